// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: widths, FSM state codes and
// the eight single-step shift mode codes.
package shift_sequencer_pkg;

  localparam int DATA_W = 4;
  localparam int MODE_W = 3;
  localparam int CNT_W  = 3;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [2:0] MODE_SHL0 = 3'b000;
  localparam logic [2:0] MODE_SHL1 = 3'b001;
  localparam logic [2:0] MODE_SHR0 = 3'b010;
  localparam logic [2:0] MODE_SHR1 = 3'b011;
  localparam logic [2:0] MODE_ASL  = 3'b100;
  localparam logic [2:0] MODE_ASR  = 3'b101;
  localparam logic [2:0] MODE_ROL  = 3'b110;
  localparam logic [2:0] MODE_ROR  = 3'b111;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/status bundle between a requester and the shift sequencer.
interface shift_sequencer_if;
  import shift_sequencer_pkg::*;

  // Handshake: start is a request pulse that is accepted only on a rising
  // edge where busy=0 (IDLE); data_in/mode/count are captured on that edge.
  // busy stays high from the cycle after acceptance through the done cycle;
  // done is a one-cycle pulse qualifying result as final. No backpressure.
  logic                start;
  logic [DATA_W-1:0]   data_in;
  logic [MODE_W-1:0]   mode;
  logic [CNT_W-1:0]    count;
  logic [DATA_W-1:0]   result;
  logic                busy;
  logic                done;
  state_t              state;

  modport master (
    output start, data_in, mode, count,
    input  result, busy, done, state
  );

  modport slave (
    input  start, data_in, mode, count,
    output result, busy, done, state
  );

endinterface

// File: rtl/shifter.sv
// Single-step 4-bit combinational shifter; Mode selects shift/rotate/fill.
module shifter
  import shift_sequencer_pkg::*;
(
  output logic [DATA_W-1:0] R,
  input  logic [DATA_W-1:0] A,
  input  logic [MODE_W-1:0] Mode
);

  always_comb begin
    R = A;
    case (Mode)
      MODE_SHL0: R = {A[2:0], 1'b0};
      MODE_SHL1: R = {A[2:0], 1'b1};
      MODE_SHR0: R = {1'b0, A[3:1]};
      MODE_SHR1: R = {1'b1, A[3:1]};
      MODE_ASL:  R = {A[2:0], 1'b0};
      // Arithmetic right replicates the sign bit into the vacated MSB.
      MODE_ASR:  R = {A[3], A[3:1]};
      MODE_ROL:  R = {A[2:0], A[3]};
      MODE_ROR:  R = {A[0], A[3:1]};
      default:   R = A;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Applies `count` single-step shifts of the selected mode to a captured
// operand, one step per cycle, then pulses done for one cycle.
module shift_sequencer
  import shift_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  shift_sequencer_if.slave   bus
);

  state_t              state_q;
  state_t              state_d;
  logic [DATA_W-1:0]   result_q;
  logic [DATA_W-1:0]   step_r;
  logic [MODE_W-1:0]   mode_q;
  logic [CNT_W-1:0]    rem_q;
  logic                busy_q;
  logic                done_q;

  shifter u_shifter (
    .R    (step_r),
    .A    (result_q),
    .Mode (mode_q)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = (bus.count == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (rem_q == 3'd1) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // busy/done are registered from the next-state decode so they line up
  // exactly with the state register without a combinational output path.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      mode_q   <= '0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            result_q <= bus.data_in;
            if (bus.count != '0) begin
              mode_q <= bus.mode;
              rem_q  <= bus.count;
            end
          end
        end
        ST_RUN: begin
          result_q <= step_r;
          rem_q    <= rem_q - 3'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.state  = state_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: driver issues requests and pushes the
// hand-computed final result and done cycle; a monitor checks each done pulse.
module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset;

  shift_sequencer_if bus ();

  shift_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  int                exp_cyc_q[$];
  int                checks = 0;
  int                passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    logic [DATA_W-1:0] e;
    int                ec;
    if (reset !== 1'b1 && bus.done === 1'b1) begin
      chk("done_implies_busy", 32'(bus.busy), 32'd1);
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got done with result %0h, expected no done (cycle %0d)",
                 bus.result, cyc);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        chk("done_result", 32'(bus.result), 32'(e));
        chk("done_cycle", cyc, ec);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge (cycle c0); the request is accepted at the next
  // rising edge and done is expected in cycle c0+lat.
  task automatic issue(input logic [3:0] d, input logic [2:0] m, input logic [2:0] c,
                       input logic [3:0] e, input int lat, input bit expect_done);
    bus.start   = 1'b1;
    bus.data_in = d;
    bus.mode    = m;
    bus.count   = c;
    if (expect_done) begin
      exp_q.push_back(e);
      exp_cyc_q.push_back(cyc + lat);
    end
    @(negedge clk);
    bus.start   = 1'b0;
    bus.data_in = 4'($urandom_range(0, 15));
    bus.mode    = 3'($urandom_range(0, 7));
    bus.count   = 3'($urandom_range(0, 7));
  endtask

  // Counts busy cycles from now until IDLE, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 30) begin
      n++;
      @(negedge clk);
    end
    if (n >= 30) begin
      checks++;
      $display("FAIL busy_timeout: busy still high after %0d cycles, expected idle", n);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.data_in = '0;
    bus.mode    = '0;
    bus.count   = '0;
    repeat (3) @(negedge clk);
    chk("reset_result", 32'(bus.result), 32'h0);
    chk("reset_busy",   32'(bus.busy),   32'h0);
    chk("reset_done",   32'(bus.done),   32'h0);
    chk("reset_state",  32'(bus.state),  32'(ST_IDLE));
    reset = 1'b0;
    @(negedge clk);
    chk("idle_state", 32'(bus.state), 32'(ST_IDLE));

    // rotate left 1001 x3: 0011, 0110, 1100
    issue(4'b1001, MODE_ROL, 3'd3, 4'b1100, 4, 1'b1);
    chk("rol_run0", 32'(bus.result), 32'h9);
    chk("rol_state", 32'(bus.state), 32'(ST_RUN));
    @(negedge clk);
    chk("rol_run1", 32'(bus.result), 32'h3);
    @(negedge clk);
    chk("rol_run2", 32'(bus.result), 32'h6);
    wait_idle(n);
    chk("rol_busy_tail", n, 2);
    chk("rol_hold", 32'(bus.result), 32'hC);

    // back-to-back: shift right fill 0, 1111 x2 -> 0011
    issue(4'b1111, MODE_SHR0, 3'd2, 4'b0011, 3, 1'b1);
    wait_idle(n);
    chk("shr0_busy", n, 3);
    chk("shr0_hold", 32'(bus.result), 32'h3);

    // arithmetic right 1000 x7 saturates at 1111
    issue(4'b1000, MODE_ASR, 3'd7, 4'b1111, 8, 1'b1);
    wait_idle(n);
    chk("asr_busy", n, 8);
    chk("asr_hold", 32'(bus.result), 32'hF);

    // count=0: straight to DONE with the captured operand
    issue(4'b0110, MODE_ROR, 3'd0, 4'b0110, 1, 1'b1);
    chk("cnt0_state", 32'(bus.state), 32'(ST_DONE));
    chk("cnt0_done",  32'(bus.done),  32'h1);
    wait_idle(n);
    chk("cnt0_busy", n, 1);

    // shift right fill 1, 0100 x3 -> 1010, 1101, 1110; start re-asserted mid-run
    issue(4'b0100, MODE_SHR1, 3'd3, 4'b1110, 4, 1'b1);
    repeat (2) begin
      bus.start   = 1'b1;
      bus.data_in = 4'($urandom_range(0, 15));
      bus.mode    = 3'($urandom_range(0, 7));
      bus.count   = 3'($urandom_range(1, 7));
      @(negedge clk);
    end
    bus.start = 1'b0;
    wait_idle(n);
    chk("ignore_busy_tail", n, 2);
    chk("ignore_hold", 32'(bus.result), 32'hE);

    // back-to-back: shift left fill 1, 0101 -> 1011
    issue(4'b0101, MODE_SHL1, 3'd1, 4'b1011, 2, 1'b1);
    wait_idle(n);
    chk("shl1_busy", n, 2);

    // arithmetic left 1011 x2 -> 0110, 1100
    issue(4'b1011, MODE_ASL, 3'd2, 4'b1100, 3, 1'b1);
    wait_idle(n);
    chk("asl_busy", n, 3);
    chk("asl_hold", 32'(bus.result), 32'hC);

    // reset during the 2nd RUN cycle of a count=5 operation: no done
    issue(4'b1010, MODE_SHL0, 3'd5, 4'b0000, 0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_result", 32'(bus.result), 32'h0);
    chk("abort_busy",   32'(bus.busy),   32'h0);
    chk("abort_done",   32'(bus.done),   32'h0);
    chk("abort_state",  32'(bus.state),  32'(ST_IDLE));
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_quiet_busy", 32'(bus.busy), 32'h0);
    chk("scoreboard_empty", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 4 bits, mode at 3 bits and count at 3 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 data_in  input  4  initial operand, captured when start is accepted.
REQ-006 mode  input  3  shift-mode code, captured when start is accepted; encoding per REQ-012.
REQ-007 count  input  3  number of single-step shifts to apply (0..7), captured when start is accepted.
REQ-008 result  output  4  working/final register value.
REQ-009 busy  output  1  high in RUN and DONE states.
REQ-010 done  output  1  single-cycle completion pulse.

Function
REQ-011 FSM states SHALL be IDLE, RUN and DONE; reset state is IDLE.
REQ-012 Mode codes for one step on value A SHALL be:
- 000: shift left, fill 0
- 001: shift left, fill 1
- 010: shift right, fill 0
- 011: shift right, fill 1
- 100: arithmetic left (same as 000)
- 101: arithmetic right, sign kept
- 110: rotate left
- 111: rotate right
REQ-013 IDLE with start=1 and count!=0: capture data_in into result, mode into mode_q, count into rem; next state RUN.
REQ-014 IDLE with start=1 and count=0: capture data_in into result; next state DONE (no shift).
REQ-015 RUN: each cycle result <= step(result, mode_q) and rem <= rem-1; when rem==1 next state DONE, else stay in RUN.
REQ-016 DONE: done=1 for exactly that cycle; next state IDLE unconditionally.
REQ-017 Latency: done SHALL assert N+1 cycles after the accepting edge for count=N≥1, and 1 cycle after it for count=0.
REQ-018 start SHALL be ignored in RUN and DONE; captured mode_q/rem SHALL NOT change while busy, regardless of input changes.
REQ-019 result SHALL hold its value in IDLE until the next accepted start; mode and count input changes SHALL NOT affect an operation in progress.
REQ-020 done and busy SHALL be registered FSM decodes; done=1 implies busy=1.
REQ-021 Back-to-back: start asserted in the IDLE cycle immediately after DONE SHALL be accepted.

Reset
REQ-022 When reset=1 at a rising edge: state=IDLE, result=4'b0000, rem=0, mode_q=3'b000, busy=0, done=0; reset SHALL take priority over start and abort any operation in progress without a done pulse.

Structure
REQ-023 The state encoding (IDLE/RUN/DONE) and the eight mode-code constants SHALL live in a shared package used by both the block and its bench.
REQ-024 The single-step combinational shift SHALL be the existing shifter module (ports R, A, Mode), instantiated once with A=result and Mode=mode_q; no other sub-module.

Verification
REQ-025 data_in=4'b1001, mode=110, count=3 -> result 0011, 0110, 1100 on successive RUN cycles; done high with result=4'b1100 four cycles after start.
REQ-026 data_in=4'b1111, mode=010, count=2 -> final result 4'b0011; done three cycles after start.
REQ-027 data_in=4'b1000, mode=101, count=7 -> result saturates at 4'b1111; busy high for 8 cycles (7 RUN + 1 DONE); done eight cycles after start.
REQ-028 data_in=4'b0110, count=0, any mode -> result=4'b0110 and done=1 one cycle after start; no RUN cycle.
REQ-029 start re-asserted with new data/mode/count during RUN -> ignored, result and timing match the first request; start in the cycle after DONE accepted.
REQ-030 reset asserted in the 2nd RUN cycle of a count=5 operation -> next cycle IDLE, result=0000, busy=0, no done pulse.
